// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle imem, buffers responses in a 2-entry queue.
// Optional perf counters (perf_fetched/perf_flushed/perf_stall) are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // PC and in-flight tracking
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;

    // Two-entry in-order queue
    logic [1:0]      count_q, count_d;
    logic            head_q, head_d;
    logic [XLEN-1:0] q_pc_q [2];
    logic [31:0]     q_instr_q [2];

    logic            deq;
    logic            issue;
    logic            wr;
    logic            tail;
    logic [2:0]      occ;
    logic [XLEN-1:0] redirect_aligned;
    logic            unused_redirect_lsbs;

    assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign id_valid = (count_q != 2'd0);
    assign deq      = id_valid & id_ready;
    assign occ      = {1'b0, count_q} + {2'b00, inflight_q};

    // Issue only while the queue plus the pending response still fits in two entries.
    assign issue = !reset & !redirect_valid &
                   ((occ < 3'd2) | ((occ == 3'd2) & deq));

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    // A response arriving in a redirect cycle is wrong-path and dropped with the queue.
    assign wr   = inflight_q & !kill_q & !redirect_valid;
    assign tail = head_q ^ count_q[0];

    assign id_pc    = q_pc_q[head_q];
    assign id_instr = q_instr_q[head_q];

    always_comb begin
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        inflight_d    = issue;
        kill_d        = redirect_valid & inflight_q;
        if (redirect_valid) begin
            pc_d = redirect_aligned;
        end else if (issue) begin
            pc_d          = pc_q + PC_STEP;
            pc_inflight_d = pc_q;
        end
    end

    always_comb begin
        count_d = count_q;
        head_d  = deq ? ~head_q : head_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            unique case ({wr, deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pc_inflight_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            head_q        <= head_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else if (wr) begin
            q_pc_q[tail]    <= pc_inflight_q;
            q_instr_q[tail] <= imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;
    logic [1:0]  flush_n;

    // Queue entries not taken by decode plus a live response dropped this cycle.
    assign flush_n = (count_q - {1'b0, deq}) + {1'b0, inflight_q & !kill_q};

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= sat_add(perf_fetched_q, {1'b0, wr});
            perf_flushed_q <= sat_add(perf_flushed_q, redirect_valid ? flush_n : 2'd0);
            perf_stall_q   <= sat_add(perf_stall_q, {1'b0, id_valid & !id_ready});
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, backpressure, redirects, PC wrap, async reset.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic [31:0] imem_addr, imem_rdata;
    logic        imem_req;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;

    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_imem_req;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_id_valid;
    logic [31:0] w_id_pc, w_id_instr;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
    logic [31:0] w_perf_fetched, w_perf_flushed, w_perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
        .perf_stall     (perf_stall)
`endif
    );

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (w_imem_addr),
        .imem_req       (w_imem_req),
        .imem_rdata     (w_imem_rdata),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .id_valid       (w_id_valid),
        .id_ready       (id_ready),
        .id_pc          (w_id_pc),
        .id_instr       (w_id_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (w_perf_fetched),
        .perf_flushed   (w_perf_flushed),
        .perf_stall     (w_perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories: one-cycle latency, word = ~address so pc and instr differ.
    always @(posedge clk) if (imem_req) imem_rdata <= ~imem_addr;
    always @(posedge clk) if (w_imem_req) w_imem_rdata <= ~w_imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Queue must never exceed two entries.
    always @(negedge clk) begin
        if (!reset) begin
            check("q_ovf", {31'b0, dut.count_q <= 2'd2}, 32'd1);
            check("q_ovf_w", {31'b0, dut_w.count_q <= 2'd2}, 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_addr_w", w_imem_addr, 32'hFFFF_FFF8);
`ifdef IF_PERF_CNT_EN
        check("rst_perf_f", perf_fetched, 32'h0);
        check("rst_perf_s", perf_stall, 32'h0);
`endif
        reset = 1'b0;
        #1;
        // cycle 0
        check("c0_req", {31'b0, imem_req}, 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        nxt(); // c1
        check("c1_valid", {31'b0, id_valid}, 32'd0);
        check("c1_addr", imem_addr, 32'h4);
        nxt(); // c2
        check("c2_valid", {31'b0, id_valid}, 32'd1);
        check("c2_pc", id_pc, 32'h0);
        check("c2_instr", id_instr, 32'hFFFF_FFFF);
        check("wrap_pc0", w_id_pc, 32'hFFFF_FFF8);
        nxt(); // c3
        check("c3_pc", id_pc, 32'h4);
        check("wrap_pc1", w_id_pc, 32'hFFFF_FFFC);
        nxt(); // c4
        check("c4_pc", id_pc, 32'h8);
        check("wrap_pc2", w_id_pc, 32'h0);
        check("wrap_instr2", w_id_instr, 32'hFFFF_FFFF);
        nxt(); // c5
        check("c5_pc", id_pc, 32'hC);

        // Backpressure for six cycles (c6..c11)
        nxt(); id_ready = 1'b0; #1;
        check("bp6_pc", id_pc, 32'h10);
        check("bp6_req", {31'b0, imem_req}, 32'd0);
        nxt(); // c7
        check("bp7_req", {31'b0, imem_req}, 32'd0);
        check("bp7_addr", imem_addr, 32'h18);
        repeat (3) nxt(); // c10
        nxt(); // c11
        check("bp11_valid", {31'b0, id_valid}, 32'd1);
        check("bp11_pc", id_pc, 32'h10);
        check("bp11_instr", id_instr, ~32'h10);
        check("bp11_addr", imem_addr, 32'h18);
        check("bp11_req", {31'b0, imem_req}, 32'd0);
        nxt(); id_ready = 1'b1; #1; // c12
        check("bp12_pc", id_pc, 32'h10);
        check("bp12_req", {31'b0, imem_req}, 32'd1);
        nxt(); check("bp13_pc", id_pc, 32'h14);
        nxt(); check("bp14_pc", id_pc, 32'h18);
        nxt(); check("bp15_pc", id_pc, 32'h1C);

        // Redirect to 0x100 with a response in flight and decode stalled
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b0; #1; // c16
        check("r1_pc", id_pc, 32'h20);
        check("r1_req", {31'b0, imem_req}, 32'd0);
        nxt(); redirect_valid = 1'b0; id_ready = 1'b1; #1; // c17
        check("r1_valid17", {31'b0, id_valid}, 32'd0);
        check("r1_addr17", imem_addr, 32'h100);
        check("r1_req17", {31'b0, imem_req}, 32'd1);
        nxt(); check("r1_valid18", {31'b0, id_valid}, 32'd0);
        nxt(); // c19
        check("r1_valid19", {31'b0, id_valid}, 32'd1);
        check("r1_pc19", id_pc, 32'h100);
        check("r1_instr19", id_instr, ~32'h100);

        // Steer to 0x10, then redirect to 0x203 while 0x10 is accepted
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h10; #1; // c20
        check("r2_pc20", id_pc, 32'h104);
        nxt(); redirect_valid = 1'b0; #1; // c21
        check("r2_addr21", imem_addr, 32'h10);
        nxt(); // c22
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h203; #1; // c23
        check("r3_valid23", {31'b0, id_valid}, 32'd1);
        check("r3_pc23", id_pc, 32'h10);
        nxt(); redirect_valid = 1'b0; #1; // c24
        check("r3_valid24", {31'b0, id_valid}, 32'd0);
        check("r3_addr24", imem_addr, 32'h200);
        nxt(); check("r3_valid25", {31'b0, id_valid}, 32'd0);
        nxt(); // c26
        check("r3_valid26", {31'b0, id_valid}, 32'd1);
        check("r3_pc26", id_pc, 32'h200);

        // Back-to-back redirects: 0x300 then 0x400
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h300; #1; // c27
        check("r4_pc27", id_pc, 32'h204);
        nxt(); redirect_pc = 32'h400; #1; // c28
        check("r4_addr28", imem_addr, 32'h300);
        check("r4_req28", {31'b0, imem_req}, 32'd0);
        nxt(); redirect_valid = 1'b0; #1; // c29
        check("r4_addr29", imem_addr, 32'h400);
        check("r4_req29", {31'b0, imem_req}, 32'd1);
        nxt(); check("r4_valid30", {31'b0, id_valid}, 32'd0);
        nxt(); check("r4_pc31", id_pc, 32'h400);
        nxt(); check("r4_pc32", id_pc, 32'h404);

        // Async reset mid-cycle with a queued entry and a response in flight
        nxt(); id_ready = 1'b0; #1; // c33
        check("ar_pc33", id_pc, 32'h408);
        #1 reset = 1'b1;
        #1;
        check("ar_valid", {31'b0, id_valid}, 32'd0);
        check("ar_req", {31'b0, imem_req}, 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_pc", id_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("ar_perf_f", perf_fetched, 32'h0);
        check("ar_perf_fl", perf_flushed, 32'h0);
        check("ar_perf_s", perf_stall, 32'h0);
`endif
        nxt();
        nxt(); id_ready = 1'b1; reset = 1'b0; #1;
        check("ar_req0", {31'b0, imem_req}, 32'd1);
        check("ar_addr0", imem_addr, 32'h0);
        nxt();
        check("ar_valid1", {31'b0, id_valid}, 32'd0);
        nxt();
        check("ar_valid2", {31'b0, id_valid}, 32'd1);
        check("ar_pc2", id_pc, 32'h0);
        check("ar_pc2_w", w_id_pc, 32'hFFFF_FFF8);

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
